fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit_pkg.sv | 16 +
 rtl/fwd_hazard_unit_match_slot.sv | 44 ++++
 rtl/fwd_hazard_unit.sv | 108 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared constants, select encoding and multicycle FSM states
package fwd_hazard_unit_pkg;

  localparam int DEF_REGNO_SEL = 4;
  localparam int DEF_NUM_STG   = 3;

  localparam int SEL_RF       = 0;
  localparam int SEL_STG_BASE = 1;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/fwd_hazard_unit_match_slot.sv
// fwd_match_slot: youngest-first forward match for one source operand plus its hazard
module fwd_match_slot
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REGNO_SEL = DEF_REGNO_SEL,
  parameter int NUM_STG   = DEF_NUM_STG,
  parameter int MUX_SEL   = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic [REGNO_SEL-1:0]         src_i,
  input  logic                         used_i,
  input  logic [NUM_STG*REGNO_SEL-1:0] dest_stg_i,
  input  logic [NUM_STG-1:0]           wr_vld_stg_i,
  input  logic [NUM_STG-1:0]           rdy_stg_i,
  input  logic                         mc_busy_i,
  input  logic [REGNO_SEL-1:0]         mc_dest_i,
  output logic [MUX_SEL-1:0]           sel_o,
  output logic                         hazard_o
);

  logic [MUX_SEL-1:0] sel;
  logic               hit;
  logic               rdy;
  logic               zero;

  // scan oldest to youngest so the youngest matching stage overwrites the rest
  always_comb begin
    sel = MUX_SEL'(SEL_RF);
    hit = 1'b0;
    rdy = 1'b1;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (wr_vld_stg_i[k] && dest_stg_i[k*REGNO_SEL +: REGNO_SEL] == src_i) begin
        sel = MUX_SEL'(k + SEL_STG_BASE);
        hit = 1'b1;
        rdy = rdy_stg_i[k];
      end
    end
  end

  assign zero     = (ZERO_REG != 0) && (src_i == '0);
  assign sel_o    = zero ? MUX_SEL'(SEL_RF) : sel;
  assign hazard_o = used_i && !zero && (hit ? !rdy : (mc_busy_i && src_i == mc_dest_i));

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: D-stage forward selects, stall/bubble, multicycle tracker and stall counter
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REGNO_SEL = DEF_REGNO_SEL,
  parameter int NUM_SRC   = 2,
  parameter int NUM_STG   = DEF_NUM_STG,
  parameter int MUX_SEL   = 2,
  parameter int ZERO_REG  = 1,
  parameter int MC_CNT_W  = 4,
  parameter int PERF_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC*REGNO_SEL-1:0] src_D,
  input  logic [NUM_SRC-1:0]           src_used_D,
  input  logic [NUM_STG*REGNO_SEL-1:0] dest_stg,
  input  logic [NUM_STG-1:0]           wr_vld_stg,
  input  logic [NUM_STG-1:0]           rdy_stg,
  input  logic                         mc_req_D,
  input  logic [REGNO_SEL-1:0]         mc_dest_D,
  input  logic [MC_CNT_W-1:0]          mc_lat_D,
  output logic [NUM_SRC*MUX_SEL-1:0]   src_sel_D,
  output logic                         stall_D,
  output logic                         bubble_E,
  output logic                         mc_busy,
  output logic                         mc_done,
  output logic [PERF_W-1:0]            stall_cnt
);

  logic [NUM_SRC-1:0]   slot_haz;
  logic                 struct_haz;
  logic                 accept;
  logic [MC_CNT_W-1:0]  lat_m1;
  mc_state_e            state_q, state_d;
  logic [MC_CNT_W-1:0]  cnt_q, cnt_d;
  logic [REGNO_SEL-1:0] dest_q, dest_d;
  logic [PERF_W-1:0]    stall_cnt_q, stall_cnt_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    fwd_match_slot #(
      .REGNO_SEL (REGNO_SEL),
      .NUM_STG   (NUM_STG),
      .MUX_SEL   (MUX_SEL),
      .ZERO_REG  (ZERO_REG)
    ) u_slot (
      .src_i        (src_D[g*REGNO_SEL +: REGNO_SEL]),
      .used_i       (src_used_D[g]),
      .dest_stg_i   (dest_stg),
      .wr_vld_stg_i (wr_vld_stg),
      .rdy_stg_i    (rdy_stg),
      .mc_busy_i    (mc_busy),
      .mc_dest_i    (dest_q),
      .sel_o        (src_sel_D[g*MUX_SEL +: MUX_SEL]),
      .hazard_o     (slot_haz[g])
    );
  end

  // a second multicycle op must wait unless the current one retires this cycle
  assign struct_haz  = mc_req_D && mc_busy && !mc_done;
  assign stall_D     = (|slot_haz) || struct_haz;
  assign bubble_E    = stall_D;
  assign accept      = mc_req_D && !stall_D;
  assign lat_m1      = (mc_lat_D == '0) ? '0 : mc_lat_D - MC_CNT_W'(1);
  assign stall_cnt_d = (stall_D && !(&stall_cnt_q)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  // state, latency counter, pending destination and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MC_IDLE;
      cnt_q       <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // next state: accept from IDLE or DONE, count down in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    case (state_q)
      MC_IDLE, MC_DONE: begin
        state_d = accept ? MC_BUSY : MC_IDLE;
        cnt_d   = accept ? lat_m1 : cnt_q;
        dest_d  = accept ? mc_dest_D : dest_q;
      end
      MC_BUSY: begin
        state_d = (cnt_q == '0) ? MC_DONE : MC_BUSY;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - MC_CNT_W'(1);
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // busy covers both BUSY and the DONE write-back cycle
  always_comb begin
    mc_busy = (state_q != MC_IDLE);
    mc_done = (state_q == MC_DONE);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: random and directed checks against a behavioural model
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src_D;
  logic [1:0]  src_used_D;
  logic [11:0] dest_stg;
  logic [2:0]  wr_vld_stg;
  logic [2:0]  rdy_stg;
  logic        mc_req_D;
  logic [3:0]  mc_dest_D;
  logic [3:0]  mc_lat_D;

  logic [3:0]  sel0, sel1;
  logic        stall0, bub0, busy0, done0;
  logic        stall1, bub1, busy1, done1;
  logic [15:0] cnt0, cnt1;

  int errs = 0;
  int checks = 0;

  int          left = 0;
  logic [3:0]  mdest = '0;
  int          scnt = 0;
  bit          st_m = 0;
  bit          acc_m = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u0 (
    .clk(clk), .rst_n(rst_n), .src_D(src_D), .src_used_D(src_used_D),
    .dest_stg(dest_stg), .wr_vld_stg(wr_vld_stg), .rdy_stg(rdy_stg),
    .mc_req_D(mc_req_D), .mc_dest_D(mc_dest_D), .mc_lat_D(mc_lat_D),
    .src_sel_D(sel0), .stall_D(stall0), .bubble_E(bub0), .mc_busy(busy0),
    .mc_done(done0), .stall_cnt(cnt0)
  );

  fwd_hazard_unit #(.ZERO_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .src_D(src_D), .src_used_D(src_used_D),
    .dest_stg(dest_stg), .wr_vld_stg(wr_vld_stg), .rdy_stg(rdy_stg),
    .mc_req_D(1'b0), .mc_dest_D(mc_dest_D), .mc_lat_D(mc_lat_D),
    .src_sel_D(sel1), .stall_D(stall1), .bubble_E(bub1), .mc_busy(busy1),
    .mc_done(done1), .stall_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {stall, sel} from the rules: first valid stage from E matching the source wins
  function automatic logic [4:0] expect_out(input bit zr, input bit req, input int lft, input logic [3:0] md);
    logic [3:0] sel;
    logic [3:0] s;
    bit haz;
    bit z;
    int m;
    sel = '0;
    haz = 0;
    for (int i = 0; i < 2; i++) begin
      s = src_D[i*4 +: 4];
      z = zr && (s == 4'd0);
      m = -1;
      for (int k = 0; k < 3; k++)
        if (m < 0 && wr_vld_stg[k] && dest_stg[k*4 +: 4] == s) m = k;
      if (z) m = -1;
      sel[i*2 +: 2] = 2'(m + 1);
      if (src_used_D[i] && !z)
        haz |= (m >= 0) ? !rdy_stg[m] : (lft > 0 && s == md);
    end
    haz |= req && (lft > 1);
    return {haz, sel};
  endfunction

  // every cycle: compare both instances against the model
  always @(negedge clk) begin
    logic [4:0] e0, e1;
    e0 = expect_out(1'b1, mc_req_D, left, mdest);
    e1 = expect_out(1'b0, 1'b0, 0, 4'd0);
    chk("sel", 32'(sel0), 32'(e0[3:0]));
    chk("stall", 32'(stall0), 32'(e0[4]));
    chk("bubble", 32'(bub0), 32'(e0[4]));
    chk("mc_busy", 32'(busy0), 32'(left > 0));
    chk("mc_done", 32'(done0), 32'(left == 1));
    chk("stall_cnt", 32'(cnt0), 32'(scnt));
    chk("sel_zr0", 32'(sel1), 32'(e1[3:0]));
    chk("stall_zr0", 32'(stall1), 32'(e1[4]));
    st_m  = e0[4];
    acc_m = mc_req_D && !e0[4];
  end

  // model state: cycles of mc_busy remaining (latency plus the done cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left  = 0;
      mdest = '0;
      scnt  = 0;
    end else begin
      if (acc_m) begin
        left  = ((mc_lat_D == 4'd0) ? 1 : int'(mc_lat_D)) + 1;
        mdest = mc_dest_D;
      end else if (left > 0) begin
        left--;
      end
      if (st_m && scnt < 65535) scnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic [1:0] u, input logic [11:0] d,
                       input logic [2:0] v, input logic [2:0] r, input logic q,
                       input logic [3:0] md, input logic [3:0] lat);
    src_D = s; src_used_D = u; dest_stg = d; wr_vld_stg = v; rdy_stg = r;
    mc_req_D = q; mc_dest_D = md; mc_lat_D = lat;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 2'b00, 12'h000, 3'b000, 3'b000, 1'b0, 4'd0, 4'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);

    step();
    drive({4'd3, 4'd3}, 2'b11, {4'd3, 4'd3, 4'd3}, 3'b111, 3'b111, 1'b0, 4'd0, 4'd1);
    @(negedge clk);
    chk("prio_sel", 32'(sel0), 32'h5);
    chk("prio_stall", 32'(stall0), 32'd0);
    step();
    wr_vld_stg = 3'b110;
    @(negedge clk);
    chk("prio_sel_noE", 32'(sel0), 32'hA);

    step();
    drive({4'd5, 4'd2}, 2'b10, {4'd5, 4'd9, 4'd5}, 3'b111, 3'b110, 1'b0, 4'd0, 4'd1);
    @(negedge clk);
    chk("lu_stall", 32'(stall0), 32'd1);
    chk("lu_bubble", 32'(bub0), 32'd1);
    chk("lu_sel", 32'(sel0), 32'h4);
    step();
    rdy_stg = 3'b111;
    @(negedge clk);
    chk("lu_release", 32'(stall0), 32'd0);

    step();
    drive({4'd0, 4'd0}, 2'b11, {4'd1, 4'd1, 4'd0}, 3'b001, 3'b000, 1'b0, 4'd0, 4'd1);
    @(negedge clk);
    chk("zr_sel", 32'(sel0), 32'h0);
    chk("zr_stall", 32'(stall0), 32'd0);
    chk("nzr_sel", 32'(sel1), 32'h5);
    chk("nzr_stall", 32'(stall1), 32'd1);

    step();
    drive({4'd1, 4'd1}, 2'b00, 12'h000, 3'b000, 3'b111, 1'b1, 4'd7, 4'd3);
    @(negedge clk);
    chk("mc_accept", 32'(stall0), 32'd0);
    step();
    drive({4'd7, 4'd7}, 2'b11, 12'h000, 3'b000, 3'b111, 1'b0, 4'd0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mc_dep_busy", 32'(busy0), 32'd1);
      chk("mc_dep_stall", 32'(stall0), 32'd1);
      chk("mc_dep_done", 32'(done0), 32'(i == 3));
    end
    @(negedge clk);
    chk("mc_dep_idle", 32'(busy0), 32'd0);
    chk("mc_dep_free", 32'(stall0), 32'd0);

    step();
    drive({4'd1, 4'd1}, 2'b00, 12'h000, 3'b000, 3'b111, 1'b1, 4'd7, 4'd2);
    @(negedge clk);
    chk("mc2_first", 32'(stall0), 32'd0);
    step();
    mc_dest_D = 4'd8;
    mc_lat_D  = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mc2_struct", 32'(stall0), 32'(i < 2));
      chk("mc2_done", 32'(done0), 32'(i == 2));
    end
    step();
    drive({4'd1, 4'd1}, 2'b00, 12'h000, 3'b000, 3'b111, 1'b0, 4'd0, 4'd1);
    @(negedge clk);
    chk("mc2_busy_b", 32'(busy0), 32'd1);
    chk("mc2_done_b", 32'(done0), 32'd0);
    @(negedge clk);
    chk("mc2_done_d", 32'(done0), 32'd1);
    @(negedge clk);
    chk("mc2_idle", 32'(busy0), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      drive({4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))}, 2'($urandom),
            {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))},
            3'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
            ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 4)));
    end

    step();
    drive({4'd5, 4'd5}, 2'b01, {4'd1, 4'd1, 4'd5}, 3'b001, 3'b000, 1'b0, 4'd0, 4'd1);
    repeat (65541) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(cnt0), 32'h0000FFFF);
    @(negedge clk);
    chk("sat_hold", 32'(cnt0), 32'h0000FFFF);

    step();
    drive({4'd1, 4'd1}, 2'b00, 12'h000, 3'b000, 3'b111, 1'b0, 4'd0, 4'd1);
    repeat (10) step();
    mc_req_D  = 1'b1;
    mc_dest_D = 4'd3;
    mc_lat_D  = 4'd6;
    step();
    mc_req_D = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    chk("arst_cnt", 32'(cnt0), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done0), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
